// File: rtl/word_to_byte_serializer.sv
// word_to_byte_serializer
// Splits each accepted 16-bit word into one or two bytes over a valid/ready
// stream. A word whose high byte is zero can be collapsed to a single byte.
// A new word can load on the same edge the final byte of the previous word
// leaves, so back-to-back words stream at one byte per cycle.

module word_to_byte_serializer #(
  parameter bit LOW_FIRST    = 1'b1,
  parameter bit SKIP_ZERO_HI = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        out_last,
  output logic        busy
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] FIRST  = 2'd1;
  localparam logic [1:0] SECOND = 2'd2;

  logic [1:0]  state;
  logic [1:0]  state_next;
  logic [15:0] word;
  logic        single;
  logic        accept;
  logic        xfer;
  logic        load_single;
  logic [7:0]  load_byte;
  logic [7:0]  second_byte;

  assign out_valid = (state == FIRST) || (state == SECOND);
  assign busy      = (state != IDLE);
  assign xfer      = out_valid && out_ready;

  // Gated by rst_n so nothing is accepted while reset is held.
  assign in_ready  = rst_n && ((state == IDLE) || (xfer && out_last));
  assign accept    = in_valid && in_ready;

  // Byte selection for the word being loaded and for the held word's second byte.
  assign load_single = SKIP_ZERO_HI && (in_data[15:8] == 8'h00);
  assign load_byte   = (load_single || LOW_FIRST) ? in_data[7:0] : in_data[15:8];
  assign second_byte = LOW_FIRST ? word[15:8] : word[7:0];

  // Next-state decision for the IDLE/FIRST/SECOND sequencer.
  always_comb begin
    // NOTE: default assignment first, so every path drives state_next and no latch is inferred.
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) state_next = FIRST;
      end
      FIRST: begin
        if (xfer) begin
          if (single) state_next = accept ? FIRST : IDLE;
          else        state_next = SECOND;
        end
      end
      SECOND: begin
        if (xfer) state_next = accept ? FIRST : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register; async reset discards any in-flight word.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments for all clocked state so every register samples pre-edge values.
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Word capture and registered byte outputs; held while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word     <= 16'h0000;
      single   <= 1'b0;
      out_data <= 8'h00;
      out_last <= 1'b0;
    end else if (accept) begin
      word     <= in_data;
      single   <= load_single;
      out_data <= load_byte;
      out_last <= load_single;
    end else if ((state == FIRST) && xfer && !single) begin
      out_data <= second_byte;
      out_last <= 1'b1;
    end
  end

endmodule

// File: tb/tb_word_to_byte_serializer.sv
// Directed bench for word_to_byte_serializer. Three instances share one
// stimulus stream: a (low first, skip zero high), b (low first, always two
// bytes) and c (high first, skip zero high). Each scenario task compares the
// observed handshake/output bundle against hand-computed values per cycle.

module tb_word_to_byte_serializer;

  typedef struct packed {
    logic       rdy;
    logic       busy;
    logic       vld;
    logic [7:0] data;
    logic       is_last;
  } obs_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] in_data;
  logic        out_ready;

  logic        a_in_ready, a_out_valid, a_out_last, a_busy;
  logic [7:0]  a_out_data;
  logic        b_in_ready, b_out_valid, b_out_last, b_busy;
  logic [7:0]  b_out_data;
  logic        c_in_ready, c_out_valid, c_out_last, c_busy;
  logic [7:0]  c_out_data;

  int n_checks = 0;
  int n_fail   = 0;

  word_to_byte_serializer #(.LOW_FIRST(1'b1), .SKIP_ZERO_HI(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_data(in_data), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_data(a_out_data), .out_last(a_out_last), .busy(a_busy));

  word_to_byte_serializer #(.LOW_FIRST(1'b1), .SKIP_ZERO_HI(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_data(in_data), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_data(b_out_data), .out_last(b_out_last), .busy(b_busy));

  word_to_byte_serializer #(.LOW_FIRST(1'b0), .SKIP_ZERO_HI(1'b1)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(c_in_ready),
    .in_data(in_data), .out_valid(c_out_valid), .out_ready(out_ready),
    .out_data(c_out_data), .out_last(c_out_last), .busy(c_busy));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t pk(int r, int b, int v, logic [7:0] d, int l);
    obs_t o;
    o.rdy     = (r != 0);
    o.busy    = (b != 0);
    o.vld     = (v != 0);
    o.data    = d;
    o.is_last = (l != 0);
    return o;
  endfunction

  // Raw bundles, plus masked versions where out_last only matters with out_valid.
  function automatic obs_t raw_a();
    return {a_in_ready, a_busy, a_out_valid, a_out_data, a_out_last};
  endfunction
  function automatic obs_t raw_b();
    return {b_in_ready, b_busy, b_out_valid, b_out_data, b_out_last};
  endfunction
  function automatic obs_t raw_c();
    return {c_in_ready, c_busy, c_out_valid, c_out_data, c_out_last};
  endfunction
  function automatic obs_t obs_a();
    return {a_in_ready, a_busy, a_out_valid, a_out_data, a_out_last & a_out_valid};
  endfunction
  function automatic obs_t obs_b();
    return {b_in_ready, b_busy, b_out_valid, b_out_data, b_out_last & b_out_valid};
  endfunction
  function automatic obs_t obs_c();
    return {c_in_ready, c_busy, c_out_valid, c_out_data, c_out_last & c_out_valid};
  endfunction

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h1234;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (raw_a() !== pk(0, 0, 0, 8'h00, 0)) begin
      n_fail++; $display("FAIL reset_a: got %h expected %h", raw_a(), pk(0, 0, 0, 8'h00, 0));
    end
    n_checks++;
    if (raw_b() !== pk(0, 0, 0, 8'h00, 0)) begin
      n_fail++; $display("FAIL reset_b: got %h expected %h", raw_b(), pk(0, 0, 0, 8'h00, 0));
    end
    n_checks++;
    if (raw_c() !== pk(0, 0, 0, 8'h00, 0)) begin
      n_fail++; $display("FAIL reset_c: got %h expected %h", raw_c(), pk(0, 0, 0, 8'h00, 0));
    end
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    in_data  = 16'h0000;
  endtask

  task automatic test_basic();
    logic v[4];
    logic [15:0] d[4];
    obs_t ea[4], eb[4], ec[4];
    v = '{1'b1, 1'b0, 1'b0, 1'b0};
    d = '{16'hA55A, 16'h0000, 16'h0000, 16'h0000};
    ea[0] = pk(1, 0, 0, 8'h00, 0); eb[0] = pk(1, 0, 0, 8'h00, 0); ec[0] = pk(1, 0, 0, 8'h00, 0);
    ea[1] = pk(0, 1, 1, 8'h5A, 0); eb[1] = pk(0, 1, 1, 8'h5A, 0); ec[1] = pk(0, 1, 1, 8'hA5, 0);
    ea[2] = pk(1, 1, 1, 8'hA5, 1); eb[2] = pk(1, 1, 1, 8'hA5, 1); ec[2] = pk(1, 1, 1, 8'h5A, 1);
    ea[3] = pk(1, 0, 0, 8'hA5, 0); eb[3] = pk(1, 0, 0, 8'hA5, 0); ec[3] = pk(1, 0, 0, 8'h5A, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = v[i]; in_data = d[i]; out_ready = 1'b1;
      #1;
      n_checks++;
      if (obs_a() !== ea[i]) begin
        n_fail++; $display("FAIL basic_a step %0d: got %h expected %h", i, obs_a(), ea[i]);
      end
      n_checks++;
      if (obs_b() !== eb[i]) begin
        n_fail++; $display("FAIL basic_b step %0d: got %h expected %h", i, obs_b(), eb[i]);
      end
      n_checks++;
      if (obs_c() !== ec[i]) begin
        n_fail++; $display("FAIL basic_c step %0d: got %h expected %h", i, obs_c(), ec[i]);
      end
    end
  endtask

  task automatic test_skip_zero_hi();
    logic v[4];
    logic [15:0] d[4];
    obs_t ea[4], eb[4], ec[4];
    v = '{1'b1, 1'b0, 1'b0, 1'b0};
    d = '{16'h0041, 16'h0000, 16'h0000, 16'h0000};
    ea[0] = pk(1, 0, 0, 8'hA5, 0); eb[0] = pk(1, 0, 0, 8'hA5, 0); ec[0] = pk(1, 0, 0, 8'h5A, 0);
    ea[1] = pk(1, 1, 1, 8'h41, 1); eb[1] = pk(0, 1, 1, 8'h41, 0); ec[1] = pk(1, 1, 1, 8'h41, 1);
    ea[2] = pk(1, 0, 0, 8'h41, 0); eb[2] = pk(1, 1, 1, 8'h00, 1); ec[2] = pk(1, 0, 0, 8'h41, 0);
    ea[3] = pk(1, 0, 0, 8'h41, 0); eb[3] = pk(1, 0, 0, 8'h00, 0); ec[3] = pk(1, 0, 0, 8'h41, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = v[i]; in_data = d[i]; out_ready = 1'b1;
      #1;
      n_checks++;
      if (obs_a() !== ea[i]) begin
        n_fail++; $display("FAIL skip_a step %0d: got %h expected %h", i, obs_a(), ea[i]);
      end
      n_checks++;
      if (obs_b() !== eb[i]) begin
        n_fail++; $display("FAIL skip_b step %0d: got %h expected %h", i, obs_b(), eb[i]);
      end
      n_checks++;
      if (obs_c() !== ec[i]) begin
        n_fail++; $display("FAIL skip_c step %0d: got %h expected %h", i, obs_c(), ec[i]);
      end
    end
  endtask

  task automatic test_stall();
    logic v[7];
    logic r[7];
    logic [15:0] d[7];
    obs_t ea[7], ec[7];
    v = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    r = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    d = '{16'h1234, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000};
    ea[0] = pk(1, 0, 0, 8'h41, 0); ec[0] = pk(1, 0, 0, 8'h41, 0);
    for (int i = 1; i < 5; i++) begin
      ea[i] = pk(0, 1, 1, 8'h34, 0); ec[i] = pk(0, 1, 1, 8'h12, 0);
    end
    ea[5] = pk(1, 1, 1, 8'h12, 1); ec[5] = pk(1, 1, 1, 8'h34, 1);
    ea[6] = pk(1, 0, 0, 8'h12, 0); ec[6] = pk(1, 0, 0, 8'h34, 0);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      in_valid = v[i]; in_data = d[i]; out_ready = r[i];
      #1;
      n_checks++;
      if (obs_a() !== ea[i]) begin
        n_fail++; $display("FAIL stall_a step %0d: got %h expected %h", i, obs_a(), ea[i]);
      end
      n_checks++;
      if (obs_c() !== ec[i]) begin
        n_fail++; $display("FAIL stall_c step %0d: got %h expected %h", i, obs_c(), ec[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic v[6];
    logic [15:0] d[6];
    obs_t ea[6], ec[6];
    v = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    d = '{16'h0102, 16'h0304, 16'h0304, 16'h0000, 16'h0000, 16'h0000};
    ea[0] = pk(1, 0, 0, 8'h12, 0); ec[0] = pk(1, 0, 0, 8'h34, 0);
    ea[1] = pk(0, 1, 1, 8'h02, 0); ec[1] = pk(0, 1, 1, 8'h01, 0);
    ea[2] = pk(1, 1, 1, 8'h01, 1); ec[2] = pk(1, 1, 1, 8'h02, 1);
    ea[3] = pk(0, 1, 1, 8'h04, 0); ec[3] = pk(0, 1, 1, 8'h03, 0);
    ea[4] = pk(1, 1, 1, 8'h03, 1); ec[4] = pk(1, 1, 1, 8'h04, 1);
    ea[5] = pk(1, 0, 0, 8'h03, 0); ec[5] = pk(1, 0, 0, 8'h04, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      in_valid = v[i]; in_data = d[i]; out_ready = 1'b1;
      #1;
      n_checks++;
      if (obs_a() !== ea[i]) begin
        n_fail++; $display("FAIL b2b_a step %0d: got %h expected %h", i, obs_a(), ea[i]);
      end
      n_checks++;
      if (obs_c() !== ec[i]) begin
        n_fail++; $display("FAIL b2b_c step %0d: got %h expected %h", i, obs_c(), ec[i]);
      end
    end
  endtask

  task automatic test_back_to_back_single();
    logic v[4];
    logic [15:0] d[4];
    obs_t ea[4], ec[4];
    v = '{1'b1, 1'b1, 1'b0, 1'b0};
    d = '{16'h0011, 16'h0022, 16'h0000, 16'h0000};
    ea[0] = pk(1, 0, 0, 8'h03, 0); ec[0] = pk(1, 0, 0, 8'h04, 0);
    ea[1] = pk(1, 1, 1, 8'h11, 1); ec[1] = pk(1, 1, 1, 8'h11, 1);
    ea[2] = pk(1, 1, 1, 8'h22, 1); ec[2] = pk(1, 1, 1, 8'h22, 1);
    ea[3] = pk(1, 0, 0, 8'h22, 0); ec[3] = pk(1, 0, 0, 8'h22, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = v[i]; in_data = d[i]; out_ready = 1'b1;
      #1;
      n_checks++;
      if (obs_a() !== ea[i]) begin
        n_fail++; $display("FAIL b2b_single_a step %0d: got %h expected %h", i, obs_a(), ea[i]);
      end
      n_checks++;
      if (obs_c() !== ec[i]) begin
        n_fail++; $display("FAIL b2b_single_c step %0d: got %h expected %h", i, obs_c(), ec[i]);
      end
    end
  endtask

  task automatic test_reset_in_flight();
    logic v[3];
    logic r[3];
    logic [15:0] d[3];
    obs_t ea[3], ec[3];
    logic pv[4];
    logic [15:0] pd[4];
    obs_t pa[4], pc[4];
    v = '{1'b1, 1'b0, 1'b0};
    r = '{1'b1, 1'b1, 1'b0};
    d = '{16'hCAFE, 16'h0000, 16'h0000};
    ea[0] = pk(1, 0, 0, 8'h22, 0); ec[0] = pk(1, 0, 0, 8'h22, 0);
    ea[1] = pk(0, 1, 1, 8'hFE, 0); ec[1] = pk(0, 1, 1, 8'hCA, 0);
    ea[2] = pk(0, 1, 1, 8'hCA, 1); ec[2] = pk(0, 1, 1, 8'hFE, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = v[i]; in_data = d[i]; out_ready = r[i];
      #1;
      n_checks++;
      if (obs_a() !== ea[i]) begin
        n_fail++; $display("FAIL rst_flight_a step %0d: got %h expected %h", i, obs_a(), ea[i]);
      end
      n_checks++;
      if (obs_c() !== ec[i]) begin
        n_fail++; $display("FAIL rst_flight_c step %0d: got %h expected %h", i, obs_c(), ec[i]);
      end
    end
    // Mid-cycle reset while the second byte is pending: outputs must drop without a clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (raw_a() !== pk(0, 0, 0, 8'h00, 0)) begin
      n_fail++; $display("FAIL rst_async_a: got %h expected %h", raw_a(), pk(0, 0, 0, 8'h00, 0));
    end
    n_checks++;
    if (raw_b() !== pk(0, 0, 0, 8'h00, 0)) begin
      n_fail++; $display("FAIL rst_async_b: got %h expected %h", raw_b(), pk(0, 0, 0, 8'h00, 0));
    end
    n_checks++;
    if (raw_c() !== pk(0, 0, 0, 8'h00, 0)) begin
      n_fail++; $display("FAIL rst_async_c: got %h expected %h", raw_c(), pk(0, 0, 0, 8'h00, 0));
    end
    pv = '{1'b1, 1'b0, 1'b0, 1'b0};
    pd = '{16'h1234, 16'h0000, 16'h0000, 16'h0000};
    pa[0] = pk(1, 0, 0, 8'h00, 0); pc[0] = pk(1, 0, 0, 8'h00, 0);
    pa[1] = pk(0, 1, 1, 8'h34, 0); pc[1] = pk(0, 1, 1, 8'h12, 0);
    pa[2] = pk(1, 1, 1, 8'h12, 1); pc[2] = pk(1, 1, 1, 8'h34, 1);
    pa[3] = pk(1, 0, 0, 8'h12, 0); pc[3] = pk(1, 0, 0, 8'h34, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rst_n = 1'b1;
      in_valid = pv[i]; in_data = pd[i]; out_ready = 1'b1;
      #1;
      n_checks++;
      if (obs_a() !== pa[i]) begin
        n_fail++; $display("FAIL post_rst_a step %0d: got %h expected %h", i, obs_a(), pa[i]);
      end
      n_checks++;
      if (obs_c() !== pc[i]) begin
        n_fail++; $display("FAIL post_rst_c step %0d: got %h expected %h", i, obs_c(), pc[i]);
      end
    end
  endtask

  task automatic test_high_first();
    logic v[4];
    logic [15:0] d[4];
    obs_t ea[4], ec[4];
    v = '{1'b1, 1'b0, 1'b0, 1'b0};
    d = '{16'hBEEF, 16'h0000, 16'h0000, 16'h0000};
    ea[0] = pk(1, 0, 0, 8'h12, 0); ec[0] = pk(1, 0, 0, 8'h34, 0);
    ea[1] = pk(0, 1, 1, 8'hEF, 0); ec[1] = pk(0, 1, 1, 8'hBE, 0);
    ea[2] = pk(1, 1, 1, 8'hBE, 1); ec[2] = pk(1, 1, 1, 8'hEF, 1);
    ea[3] = pk(1, 0, 0, 8'hBE, 0); ec[3] = pk(1, 0, 0, 8'hEF, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = v[i]; in_data = d[i]; out_ready = 1'b1;
      #1;
      n_checks++;
      if (obs_a() !== ea[i]) begin
        n_fail++; $display("FAIL high_first_a step %0d: got %h expected %h", i, obs_a(), ea[i]);
      end
      n_checks++;
      if (obs_c() !== ec[i]) begin
        n_fail++; $display("FAIL high_first_c step %0d: got %h expected %h", i, obs_c(), ec[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_skip_zero_hi();
    test_stall();
    test_back_to_back();
    test_back_to_back_single();
    test_reset_in_flight();
    test_high_first();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
